// File: rtl/start_gen_pkg.sv
// Shared types for the multi-channel start/trigger generator.
package start_gen_pkg;

  // Per-channel operating mode as encoded in MODE_REG.
  typedef enum logic [1:0] {
    LEVEL    = 2'd0,
    PULSE    = 2'd1,
    PERIODIC = 2'd2,
    RSVD     = 2'd3
  } mode_t;

  // Channel sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    HIGH  = 2'd2,
    LOW   = 2'd3
  } state_t;

endpackage

// File: rtl/start_chan.sv
// One start channel: edge detect, configuration latch, counter and sequencer.
module start_chan
  import start_gen_pkg::*;
#(
  parameter int unsigned CntW = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            s_sync_i,
  input  logic [1:0]      mode_i,
  input  logic [CntW-1:0] delay_i,
  input  logic [CntW-1:0] width_i,
  input  logic [CntW-1:0] period_i,
  output logic            start_o,
  output logic            busy_o
);

  localparam logic [CntW-1:0] One = CntW'(1);

  state_t          state_q, state_d;
  mode_t           mode_q, mode_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW-1:0] w_q, w_d;
  logic [CntW-1:0] low_q, low_d;
  logic            s_d_q;
  logic            start_q, start_d;
  logic            busy_q, busy_d;

  logic            rise, fall;
  mode_t           mode_in;
  logic            mode_in_seq;
  logic [CntW-1:0] w_in;
  logic [CntW-1:0] low_in;

  assign rise        = s_sync_i & ~s_d_q;
  assign fall        = ~s_sync_i & s_d_q;
  assign mode_in     = mode_t'(mode_i);
  assign mode_in_seq = (mode_in == PULSE) || (mode_in == PERIODIC);
  assign w_in        = (width_i == '0) ? One : width_i;
  // Low phase length; zero means the periodic output never drops.
  assign low_in      = (period_i > w_in) ? (period_i - w_in) : '0;

  // State, counter, latched configuration and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      mode_q  <= LEVEL;
      cnt_q   <= '0;
      w_q     <= '0;
      low_q   <= '0;
      s_d_q   <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      w_q     <= w_d;
      low_q   <= low_d;
      s_d_q   <= s_sync_i;
      start_q <= start_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state, counter reloads and configuration latch on accepted rise.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    w_d     = w_q;
    low_d   = low_q;
    unique case (state_q)
      IDLE: begin
        if (rise && mode_in_seq) begin
          mode_d = mode_in;
          w_d    = w_in;
          low_d  = low_in;
          if (delay_i != '0) begin
            state_d = DELAY;
            cnt_d   = delay_i - One;
          end else begin
            state_d = HIGH;
            cnt_d   = w_in - One;
          end
        end
      end
      DELAY: begin
        if (cnt_q == '0) begin
          state_d = HIGH;
          cnt_d   = w_q - One;
        end else begin
          cnt_d = cnt_q - One;
        end
      end
      HIGH: begin
        if (cnt_q == '0) begin
          if (mode_q == PERIODIC) begin
            if (low_q != '0) begin
              state_d = LOW;
              cnt_d   = low_q - One;
            end else begin
              cnt_d = w_q - One;
            end
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - One;
        end
      end
      LOW: begin
        if (cnt_q == '0) begin
          state_d = HIGH;
          cnt_d   = w_q - One;
        end else begin
          cnt_d = cnt_q - One;
        end
      end
      default: state_d = IDLE;
    endcase
    // A periodic stop overrides any terminal-count transition.
    if ((state_q != IDLE) && (mode_q == PERIODIC) && fall) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  // Output next values: level passthrough while idle, else decoded from next state.
  always_comb begin
    start_d = 1'b0;
    busy_d  = (state_d != IDLE);
    if ((state_q == IDLE) && (state_d == IDLE)) begin
      start_d = ~mode_in_seq & s_sync_i;
    end else begin
      start_d = (state_d == HIGH);
    end
  end

  assign start_o = start_q;
  assign busy_o  = busy_q;

endmodule

// File: rtl/synchronizer_n.sv
// Multi-stage flip-flop synchronizer for a single bit crossing into clk_i.
module synchronizer_n #(
  parameter int unsigned Stages = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [Stages-1:0] sync_q;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[Stages-2:0], d_i};
    end
  end

  assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/start_gen.sv
// Multi-channel start/trigger generator: N synchronised, independently moded channels.
module start_gen
  import start_gen_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic [N-1:0]       START_REG,
  input  logic [2*N-1:0]     MODE_REG,
  input  logic [CNT_W*N-1:0] DELAY_REG,
  input  logic [CNT_W*N-1:0] WIDTH_REG,
  input  logic [CNT_W*N-1:0] PERIOD_REG,
  output logic [N-1:0]       start,
  output logic [N-1:0]       busy
);

  for (genvar i = 0; i < N; i++) begin : g_chan
    logic s_sync;

    synchronizer_n #(
      .Stages(2)
    ) u_sync (
      .clk_i (aclk),
      .rst_ni(aresetn),
      .d_i   (START_REG[i]),
      .q_o   (s_sync)
    );

    start_chan #(
      .CntW(CNT_W)
    ) u_chan (
      .clk_i   (aclk),
      .rst_ni  (aresetn),
      .s_sync_i(s_sync),
      .mode_i  (MODE_REG[2*i +: 2]),
      .delay_i (DELAY_REG[CNT_W*i +: CNT_W]),
      .width_i (WIDTH_REG[CNT_W*i +: CNT_W]),
      .period_i(PERIOD_REG[CNT_W*i +: CNT_W]),
      .start_o (start[i]),
      .busy_o  (busy[i])
    );
  end

endmodule

// File: doc/start_gen.md
# start_gen

Multi-channel start/trigger generator, parametrised successor to the single-bit start block. It resynchronises N software start bits into the `aclk` domain and drives N registered start outputs. Each channel runs in one of three modes: level, one-shot delayed pulse, or periodic pulse train. The block sits between the AXI-lite register bank and the timed-processor / signal-generator start inputs.

## Interface
Parameters:
- `N`, default 4: number of channels, 1..32.
- `CNT_W`, default 16: width of the delay, width and period counters.

Ports:
- `aclk`  in  1  clock; the only clock.
- `aresetn`  in  1  reset, asynchronous, active-low.
- `START_REG`  in  N  per-channel start bits, driven from the register clock domain.
- `MODE_REG`  in  2*N  per-channel mode, channel i at bits [2i+1:2i]: 0 LEVEL, 1 PULSE, 2 PERIODIC, 3 reserved (behaves as LEVEL).
- `DELAY_REG`  in  CNT_W*N  per-channel delay in cycles, from edge to first output rise.
- `WIDTH_REG`  in  CNT_W*N  per-channel high time in cycles; 0 is treated as 1.
- `PERIOD_REG`  in  CNT_W*N  per-channel rise-to-rise period in cycles (PERIODIC mode only).
- `start`  out  N  start outputs, registered.
- `busy`  out  N  channel FSM not in IDLE, registered.

## Operation
- Each `START_REG[i]` passes through its own 2-FF synchronizer, producing `s_sync[i]`. A registered copy `s_d[i]` gives `rise = s_sync & ~s_d` and `fall = ~s_sync & s_d`.
- `MODE_REG`, `DELAY_REG`, `WIDTH_REG` and `PERIOD_REG` are quasi-static. Software must keep them stable from before raising `START_REG` until the channel is idle.
  - The channel latches mode, delay, width and period into local registers on `rise` while in IDLE.
  - Register changes while a channel is busy have no effect on that channel.
- LEVEL mode: `start[i]` follows `s_sync[i]` through the output register. The FSM stays in IDLE and `busy` stays 0.
- PULSE and PERIODIC modes use a per-channel FSM with states IDLE, DELAY, HIGH, LOW:
  - IDLE, on `rise`: go to DELAY if the latched delay is >0, otherwise go to HIGH.
  - DELAY: count down the latched delay, then go to HIGH.
  - HIGH: output high for W = max(WIDTH,1) cycles.
    - PULSE: then go to IDLE.
    - PERIODIC with P > W: then go to LOW.
    - PERIODIC with P <= W (this includes P = 0): stay in HIGH, with output continuously high.
  - LOW: output low for P−W cycles, then go to HIGH.
  - PERIODIC, `fall` in any non-IDLE state: go to IDLE immediately; `start` is 0 on the next cycle.
  - PULSE, `fall`: ignored; the pulse always completes.
  - `rise` while not in IDLE: ignored; there is no retrigger.
- Counters are CNT_W bits and unsigned. P−W is computed at latch time in CNT_W bits, and only when P > W. Counters never wrap: a counter reload occurs at terminal count.
- A simultaneous `fall` and HIGH-terminal event in PERIODIC mode: `fall` wins and the FSM goes to IDLE.
- Channels are fully independent and may be in different modes.

## Timing
- Reset: `start`, `busy`, the synchronizer FFs, `s_d`, the counters and the latched configuration are all 0; every FSM is in IDLE. Reset asserted mid-operation aborts all channels asynchronously.
- Let T be the first `aclk` edge at which the first synchronizer FF samples `START_REG[i]`=1. `s_sync` is then high after edge T+1, and `rise` is true during the following cycle.
- LEVEL: `start[i]` rises after edge T+2, a latency of 3 cycles. The falling edge has the same latency.
- PULSE/PERIODIC: the first `start[i]` rise comes after edge T+2+D, where D is the latched delay. It stays high exactly W cycles.
- PERIODIC: successive rises are exactly P cycles apart.
- PERIODIC stop: `start[i]` is 0 three cycles after `START_REG` falls.
- `busy[i]` rises in the same cycle the FSM leaves IDLE. It falls in the same cycle `start` falls at the end of a PULSE, or at a PERIODIC abort.
- After IDLE is re-entered, a new `rise` is accepted on the next cycle.

## Structure
- Package `start_gen_pkg`:
  - `mode_t` enum: LEVEL, PULSE, PERIODIC, RSVD.
  - `state_t` enum: IDLE, DELAY, HIGH, LOW.
- Sub-module `start_chan`: one channel's edge detect, configuration latch, counters and FSM. `start_gen` instantiates it N times in a generate loop.
- The existing `synchronizer_n` is reused: one instance per START bit.

## Test plan
- Reset release with all registers 0: `start`=0 and `busy`=0 for 20 cycles. Then LEVEL on ch0: raise START_REG[0] → `start[0]` high 3 cycles later; drop it → low 3 cycles later.
- PULSE ch1, DELAY=5, WIDTH=4: START rise at T → `start[1]` high for exactly 4 cycles beginning after edge T+7. Dropping START during the pulse does not shorten it. A re-raise during `busy` is ignored.
- PULSE with WIDTH=0, DELAY=0 → a single 1-cycle pulse after edge T+2.
- PERIODIC ch2, DELAY=0, WIDTH=3, PERIOD=10 → rises 10 cycles apart, each 3 high. START dropped mid-HIGH → `start` is 0 three cycles later and `busy` falls. Repeat with PERIOD=2 → `start` continuously high until stop.
- All 4 channels in different modes, started on the same cycle → each matches its own single-channel reference model. Changing `MODE_REG` or `DELAY_REG` while busy has no effect.
- Assert `aresetn` mid-DELAY and mid-HIGH → all outputs 0 immediately. After release no pulse appears until a new START rise.
